rvj1_ifu: RTL and testbench

Instruction fetch unit, directly upstream of the decoder. It issues word-aligned fetch requests to instruction memory over a req/gnt/rvalid interface and buffers in-order responses in a small FIFO. It presents instructions to the decoder over a valid/ready handshake (ifu_instr_o/ifu_valid_o/ifu_ready_i). It handles redirects (jump/branch) by flushing buffered and in-flight instructions.

---
 rtl/rvj1_defines.sv | 19 +
 rtl/rvj1_fifo.sv | 60 ++++++
 rtl/rvj1_ifu.sv | 135 +++++++++++++
 tb/tb_rvj1_ifu.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvj1_defines.sv
// Shared types and defaults for the rvj1 front end.
// Imported by the fetch unit and its buffer.
package rvj1_defines;

    localparam int unsigned XLEN = 32;
    localparam int unsigned IFU_FIFO_DEPTH = 4;
    localparam logic [XLEN-1:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifu_entry_t;

    typedef enum logic {
        S_BOOT  = 1'b0,
        S_FETCH = 1'b1
    } ifu_state_e;

endpackage

// File: rtl/rvj1_fifo.sv
// Synchronous FIFO with flush and occupancy count.
// Push while full is accepted only together with a pop.
module rvj1_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/rvj1_ifu.sv
// Instruction fetch unit: credit-limited requests, in-order
// response buffering and redirect flush ahead of the decoder.
module rvj1_ifu
    import rvj1_defines::*;
#(
    parameter logic [XLEN-1:0] BOOT_ADDR  = DEFAULT_BOOT_ADDR,
    parameter int unsigned     FIFO_DEPTH = IFU_FIFO_DEPTH
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    output logic            instr_req_o,
    output logic [XLEN-1:0] instr_addr_o,
    input  logic            instr_gnt_i,
    input  logic            instr_rvalid_i,
    input  logic [XLEN-1:0] instr_rdata_i,
    input  logic            jmp_valid_i,
    input  logic [XLEN-1:0] jmp_addr_i,
    output logic [XLEN-1:0] ifu_instr_o,
    output logic [XLEN-1:0] ifu_pc_o,
    output logic            ifu_valid_o,
    input  logic            ifu_ready_i
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    ifu_state_e      state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] jmp_target;
    logic [CW-1:0]   outstanding_cnt;
    logic [CW-1:0]   discard_cnt;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fire;
    logic            drop;
    logic            push;
    logic            pop;
    ifu_entry_t      push_entry;
    ifu_entry_t      head;
    logic            unused_jmp_lsbs;

    assign jmp_target      = {jmp_addr_i[XLEN-1:2], 2'b00};
    assign unused_jmp_lsbs = ^jmp_addr_i[1:0];

    // Buffered plus in-flight never exceeds the buffer size,
    // so every response is guaranteed a slot.
    assign credit_used = {1'b0, outstanding_cnt} + {1'b0, fifo_count};
    assign instr_req_o = (state == S_FETCH) && !jmp_valid_i &&
                         (credit_used < (CW+1)'(FIFO_DEPTH));
    assign instr_addr_o = fetch_pc;
    assign fire         = instr_req_o && instr_gnt_i;

    assign drop = discard_cnt != '0;
    assign push = instr_rvalid_i && !drop && !jmp_valid_i;
    assign pop  = ifu_valid_o && ifu_ready_i;

    assign push_entry.pc    = resp_pc;
    assign push_entry.instr = instr_rdata_i;

    assign ifu_valid_o = !fifo_empty && !jmp_valid_i;
    assign ifu_instr_o = fifo_empty ? '0 : head.instr;
    assign ifu_pc_o    = fifo_empty ? '0 : head.pc;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= S_BOOT;
        end else begin
            unique case (1'b1)
                jmp_valid_i:       state <= S_FETCH;
                state == S_BOOT:   state <= S_FETCH;
                default:           state <= state;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fetch_pc <= BOOT_ADDR;
            resp_pc  <= BOOT_ADDR;
        end else if (jmp_valid_i) begin
            fetch_pc <= jmp_target;
            resp_pc  <= jmp_target;
        end else begin
            if (fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (push) begin
                resp_pc <= resp_pc + XLEN'(4);
            end
        end
    end

    // Everything still in flight at a redirect belongs to the old path,
    // including a response landing in the redirect cycle itself.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            outstanding_cnt <= '0;
            discard_cnt     <= '0;
        end else begin
            outstanding_cnt <= outstanding_cnt + CW'(fire)
                               - CW'(instr_rvalid_i);
            if (jmp_valid_i) begin
                discard_cnt <= outstanding_cnt - CW'(instr_rvalid_i);
            end else if (instr_rvalid_i && drop) begin
                discard_cnt <= discard_cnt - CW'(1);
            end
        end
    end

    rvj1_fifo #(
        .WIDTH ($bits(ifu_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .flush (jmp_valid_i),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    a_credit : assert property (@(posedge clk_i) disable iff (!rstn_i)
        outstanding_cnt <= CW'(FIFO_DEPTH));
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(push && fifo_full && !pop));
    a_no_orphan_resp : assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(instr_rvalid_i && outstanding_cnt == '0));

endmodule

// File: tb/tb_rvj1_ifu.sv
// Bench for rvj1_ifu: directed scenarios plus randomized traffic
// checked against an address-stream model of sequential fetch.
module tb_rvj1_ifu;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        jmp_valid_i;
    logic [31:0] jmp_addr_i;
    logic [31:0] ifu_instr_o;
    logic [31:0] ifu_pc_o;
    logic        ifu_valid_o;
    logic        ifu_ready_i;

    int checks = 0;
    int failures = 0;

    int gnt_budget = -1;
    int resp_budget = -1;
    bit gnt_random = 1'b0;
    bit resp_random = 1'b0;
    int grant_cnt = 0;
    int pop_cnt = 0;

    logic [31:0] mem_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    bit          hold_prev;
    logic [31:0] hold_addr;

    rvj1_ifu dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .jmp_valid_i    (jmp_valid_i),
        .jmp_addr_i     (jmp_addr_i),
        .ifu_instr_o    (ifu_instr_o),
        .ifu_pc_o       (ifu_pc_o),
        .ifu_valid_o    (ifu_valid_o),
        .ifu_ready_i    (ifu_ready_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk_i);
            if (ifu_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic do_reset(input logic rdy);
        @(posedge clk_i); #1;
        rstn_i = 1'b0;
        jmp_valid_i = 1'b0;
        jmp_addr_i = '0;
        ifu_ready_i = rdy;
        @(negedge clk_i);
        chk("rst_req", 32'(instr_req_o), 32'd0);
        chk("rst_addr", instr_addr_o, 32'h0);
        chk("rst_valid", 32'(ifu_valid_o), 32'd0);
        chk("rst_instr", ifu_instr_o, 32'h0);
        chk("rst_pc", ifu_pc_o, 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        grant_cnt = 0;
        pop_cnt = 0;
    endtask

    // Instruction memory: grants per budget, answers in order, >=1 cycle later.
    initial begin
        instr_gnt_i = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i = '0;
        forever begin
            @(posedge clk_i); #1;
            if (!rstn_i) mem_q.delete();
            instr_gnt_i = (gnt_budget != 0) &&
                          (!gnt_random || $urandom_range(0, 3) != 0);
            if (rstn_i && mem_q.size() > 0 && resp_budget != 0 &&
                (!resp_random || $urandom_range(0, 2) != 0)) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i = mem_word(mem_q.pop_front());
                if (resp_budget > 0) resp_budget--;
            end else begin
                instr_rvalid_i = 1'b0;
                instr_rdata_i = $urandom;
            end
        end
    end

    // Reference: the decoder sees target, target+4, ... after every redirect.
    initial begin
        exp_pc = 32'h0;
        exp_req = 32'h0;
        hold_prev = 1'b0;
        hold_addr = '0;
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                exp_pc = 32'h0;
                exp_req = 32'h0;
                hold_prev = 1'b0;
                mem_q.delete();
            end else if (jmp_valid_i) begin
                chk("jmp_no_req", 32'(instr_req_o), 32'd0);
                chk("jmp_no_valid", 32'(ifu_valid_o), 32'd0);
                exp_pc = {jmp_addr_i[31:2], 2'b00};
                exp_req = exp_pc;
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("hold_req", 32'(instr_req_o), 32'd1);
                    chk("hold_addr", instr_addr_o, hold_addr);
                end
                if (instr_req_o && instr_gnt_i) begin
                    chk("req_addr", instr_addr_o, exp_req);
                    exp_req = exp_req + 32'd4;
                    mem_q.push_back(instr_addr_o);
                    grant_cnt++;
                    if (gnt_budget > 0) gnt_budget--;
                    chk("credit", 32'(mem_q.size() <= DEPTH), 32'd1);
                end
                hold_prev = instr_req_o && !instr_gnt_i;
                hold_addr = instr_addr_o;
                if (ifu_valid_o && ifu_ready_i) begin
                    chk("pop_pc", ifu_pc_o, exp_pc);
                    chk("pop_instr", ifu_instr_o, mem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    pop_cnt++;
                end
            end
        end
    end

    initial begin
        bit hit;
        rstn_i = 1'b0;
        jmp_valid_i = 1'b0;
        jmp_addr_i = '0;
        ifu_ready_i = 1'b0;

        // Boot sequence and first-instruction latency
        do_reset(1'b1);
        @(negedge clk_i);
        chk("boot_no_req", 32'(instr_req_o), 32'd0);
        @(negedge clk_i);
        chk("t1_req0", 32'(instr_req_o), 32'd1);
        chk("t1_addr0", instr_addr_o, 32'h0);
        @(negedge clk_i);
        chk("t1_addr4", instr_addr_o, 32'h4);
        chk("t1_not_yet", 32'(ifu_valid_o), 32'd0);
        @(negedge clk_i);
        chk("t1_valid_c3", 32'(ifu_valid_o), 32'd1);
        chk("t1_pc0", ifu_pc_o, 32'h0);
        chk("t1_instr0", ifu_instr_o, mem_word(32'h0));
        chk("t1_addr8", instr_addr_o, 32'h8);
        @(negedge clk_i);
        chk("t1_pc4", ifu_pc_o, 32'h4);
        @(negedge clk_i);
        chk("t1_pc8", ifu_pc_o, 32'h8);
        chk("t1_instr8", ifu_instr_o, mem_word(32'h8));

        // Backpressure: credit stops at the buffer depth
        do_reset(1'b0);
        repeat (12) @(negedge clk_i);
        chk("t2_grants", 32'(grant_cnt), 32'd4);
        chk("t2_req_off", 32'(instr_req_o), 32'd0);
        chk("t2_valid", 32'(ifu_valid_o), 32'd1);
        chk("t2_head", ifu_pc_o, 32'h0);
        @(posedge clk_i); #1;
        ifu_ready_i = 1'b1;
        repeat (12) @(negedge clk_i);
        chk("t2_drained", 32'(pop_cnt >= 5), 32'd1);
        chk("t2_resumed", 32'(grant_cnt > 4), 32'd1);

        // Redirect with two in flight and one response in the jump cycle
        gnt_budget = 0;
        resp_budget = 0;
        do_reset(1'b1);
        @(negedge clk_i);
        gnt_budget = 2;
        repeat (2) @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("t4_req_stable", 32'(instr_req_o), 32'd1);
            chk("t4_addr_stable", instr_addr_o, 32'h8);
            chk("t3_no_data", 32'(ifu_valid_o), 32'd0);
        end
        resp_budget = 1;
        @(posedge clk_i); #1;
        jmp_valid_i = 1'b1;
        jmp_addr_i = 32'h0000_0103;
        @(posedge clk_i); #1;
        jmp_valid_i = 1'b0;
        @(negedge clk_i);
        chk("t3_discard", 32'(dut.discard_cnt), 32'd1);
        chk("t3_empty", 32'(ifu_valid_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk_i);
            chk("t3_req", 32'(instr_req_o), 32'd1);
            chk("t3_addr", instr_addr_o, 32'h100);
        end
        resp_budget = -1;
        gnt_budget = 1;
        repeat (2) @(negedge clk_i);
        chk("t4_adv_on_gnt", instr_addr_o, 32'h104);
        gnt_budget = -1;
        wait_valid("t3_wait", 20);
        chk("t3_first_pc", ifu_pc_o, 32'h100);
        chk("t3_first_instr", ifu_instr_o, mem_word(32'h100));

        // Randomized traffic with occasional redirects
        gnt_random = 1'b1;
        resp_random = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk_i); #1;
            ifu_ready_i = $urandom_range(0, 3) != 0;
            jmp_valid_i = $urandom_range(0, 29) == 0;
            jmp_addr_i = $urandom;
        end
        @(posedge clk_i); #1;
        jmp_valid_i = 1'b0;
        ifu_ready_i = 1'b1;

        // Back-to-back redirects: latest target wins
        @(posedge clk_i); #1;
        jmp_valid_i = 1'b1;
        jmp_addr_i = 32'h0000_0041;
        @(posedge clk_i); #1;
        jmp_addr_i = 32'h0000_0080;
        @(posedge clk_i); #1;
        jmp_valid_i = 1'b0;
        wait_valid("t5_wait", 60);
        chk("t5_pc", ifu_pc_o, 32'h80);
        chk("t5_instr", ifu_instr_o, mem_word(32'h80));

        // Address wrap at the top of memory
        @(posedge clk_i); #1;
        jmp_valid_i = 1'b1;
        jmp_addr_i = 32'hFFFF_FFF8;
        @(posedge clk_i); #1;
        jmp_valid_i = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (instr_req_o && instr_gnt_i &&
                instr_addr_o == 32'hFFFF_FFFC) begin
                hit = 1'b1;
                break;
            end
        end
        chk("t6_top_granted", 32'(hit), 32'd1);
        @(negedge clk_i);
        chk("t6_wrap_addr", instr_addr_o, 32'h0);

        // Asynchronous reset with buffered data
        @(posedge clk_i); #1;
        ifu_ready_i = 1'b0;
        wait_valid("t6_fill", 60);
        repeat (3) @(negedge clk_i);
        @(posedge clk_i); #3;
        rstn_i = 1'b0;
        #1;
        chk("t6_arst_req", 32'(instr_req_o), 32'd0);
        chk("t6_arst_addr", instr_addr_o, 32'h0);
        chk("t6_arst_valid", 32'(ifu_valid_o), 32'd0);
        chk("t6_arst_instr", ifu_instr_o, 32'h0);
        chk("t6_arst_pc", ifu_pc_o, 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        ifu_ready_i = 1'b1;
        gnt_random = 1'b0;
        resp_random = 1'b0;
        wait_valid("t6_restart", 20);
        chk("t6_restart_pc", ifu_pc_o, 32'h0);
        repeat (4) @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
